gray_arb: RTL and testbench

Two-requester round-robin controller that shares one external 3-bit Gray counter (000→001→011→010→110→111→101→100→000, sticky overflow, synchronous clear, count enable). Each granted requester gets the counter cleared, advanced by a requested number of steps, and the final code and overflow flag returned. The block sits between the client logic and the counter instance, and is the only driver of the counter's clear and enable inputs.

---
 rtl/gray_arb.sv | 63 ++++++
 tb/tb_gray_arb.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/gray_arb.sv
// gray_arb: two-requester round-robin controller for one shared external 3-bit Gray counter
module gray_arb (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [3:0] Len0,
  input  logic [3:0] Len1,
  input  logic [2:0] CntOut,
  input  logic       CntOvf,
  output logic       CntReset,
  output logic       CntEn,
  output logic [1:0] Grant,
  output logic       Busy,
  output logic       Done,
  output logic       DoneId,
  output logic [2:0] Result,
  output logic       ResultOvf
);
  localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [3:0] rem;
  logic       owner, last, pick;
  // on a tie the requester not served last wins; otherwise whoever is asking
  assign pick     = (Req0 & Req1) ? ~last : Req1;
  assign Busy     = state != IDLE;
  assign CntEn    = state == RUN;
  assign CntReset = Reset | (state == CLEAR);
  assign Grant    = Busy ? {owner, ~owner} : 2'b00;
  always_ff @(posedge Clk)
    if (Reset) begin
      state     <= IDLE;
      rem       <= 4'd0;
      owner     <= 1'b0;
      last      <= 1'b1;
      Done      <= 1'b0;
      DoneId    <= 1'b0;
      Result    <= 3'd0;
      ResultOvf <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Req0 | Req1) begin
          owner <= pick;
          rem   <= pick ? Len1 : Len0;
          state <= CLEAR;
        end
        CLEAR: state <= (rem == 4'd0) ? DONE : RUN;
        RUN: begin
          rem <= rem - 4'd1;
          if (rem == 4'd1) state <= DONE;
        end
        default: begin
          Result    <= CntOut;
          ResultOvf <= CntOvf;
          DoneId    <= owner;
          Done      <= 1'b1;
          last      <= owner;
          state     <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_gray_arb.sv
// tb_gray_arb: table-driven check of gray_arb against a behavioral Gray counter
module tb_gray_arb;
  logic       Clk, Reset, Req0, Req1;
  logic [3:0] Len0, Len1;
  logic [2:0] CntOut, Result;
  logic       CntOvf, CntReset, CntEn, Busy, Done, DoneId, ResultOvf;
  logic [1:0] Grant;
  int passed = 0, total = 0;

  gray_arb dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Len0(Len0), .Len1(Len1),
    .CntOut(CntOut), .CntOvf(CntOvf), .CntReset(CntReset), .CntEn(CntEn),
    .Grant(Grant), .Busy(Busy), .Done(Done), .DoneId(DoneId),
    .Result(Result), .ResultOvf(ResultOvf)
  );

  logic [2:0] cb;
  logic       ovf_m;
  always_ff @(posedge Clk)
    if (CntReset) begin
      cb    <= 3'd0;
      ovf_m <= 1'b0;
    end else if (CntEn) begin
      cb <= cb + 3'd1;
      if (cb == 3'd7) ovf_m <= 1'b1;
    end
  assign CntOut = cb ^ (cb >> 1);
  assign CntOvf = ovf_m;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       r0, r1;
    logic [3:0] l0, l1;
    int         chg_cyc;
    logic [3:0] chg_len;
    logic       id;
    logic [2:0] res;
    logic       ovf;
    int         en_cnt;
    int         done_cyc;
  } job_t;
  job_t jobs[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_job(input job_t v, input int n);
    int en = 0, dc = 0, clr1 = 0, g1 = 0, b1 = 0;
    logic id = 1'b0, ovf = 1'b0;
    logic [2:0] res = 3'd0;
    Req0 = v.r0; Req1 = v.r1; Len0 = v.l0; Len1 = v.l1;
    for (int c = 1; c <= 60 && dc == 0; c++) begin
      @(negedge Clk);
      if (CntEn) en++;
      if (c == 1) begin clr1 = CntReset; g1 = Grant; b1 = Busy; end
      if (c == v.chg_cyc) begin Len0 = v.chg_len; Len1 = v.chg_len; end
      if (Done) begin
        dc = c; id = DoneId; res = Result; ovf = ResultOvf;
        Req0 = 1'b0; Req1 = 1'b0;
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    check($sformatf("job%0d clear", n), clr1, 1);
    check($sformatf("job%0d grant", n), g1, v.id ? 2 : 1);
    check($sformatf("job%0d busy", n), b1, 1);
    check($sformatf("job%0d en_cycles", n), en, v.en_cnt);
    check($sformatf("job%0d done_cycle", n), dc, v.done_cyc);
    check($sformatf("job%0d done_id", n), id, v.id);
    check($sformatf("job%0d result", n), res, v.res);
    check($sformatf("job%0d result_ovf", n), ovf, v.ovf);
    @(negedge Clk);
    check($sformatf("job%0d idle_after", n), Busy, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; Len0 = 4'd0; Len1 = 4'd0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    int k, nd;
    jobs[0] = '{1, 0, 3,  0, 0, 0, 0, 3'b010, 0, 3,  6};
    jobs[1] = '{0, 1, 0,  8, 0, 0, 1, 3'b000, 1, 8,  11};
    jobs[2] = '{0, 1, 0, 15, 0, 0, 1, 3'b100, 1, 15, 18};
    jobs[3] = '{1, 0, 0,  0, 0, 0, 0, 3'b000, 0, 0,  3};
    jobs[4] = '{1, 0, 1,  0, 0, 0, 0, 3'b001, 0, 1,  4};
    jobs[5] = '{1, 0, 3,  0, 3, 7, 0, 3'b010, 0, 3,  6};
    Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; Len0 = 4'd0; Len1 = 4'd0;
    repeat (2) @(negedge Clk);
    check("rst grant", Grant, 0);
    check("rst busy", Busy, 0);
    check("rst cnt_en", CntEn, 0);
    check("rst cnt_reset", CntReset, 1);
    check("rst done", Done, 0);
    check("rst done_id", DoneId, 0);
    check("rst result", Result, 0);
    check("rst result_ovf", ResultOvf, 0);
    Reset = 1'b0;
    @(negedge Clk);
    check("idle cnt_reset", CntReset, 0);
    for (int i = 0; i < 6; i++) run_job(jobs[i], i);

    // both requesters held: first tie after reset goes to 0, then alternate
    do_reset();
    Req0 = 1'b1; Req1 = 1'b1; Len0 = 4'd2; Len1 = 4'd5;
    k = 0;
    for (int c = 0; c < 100 && k < 4; c++) begin
      @(negedge Clk);
      if (Done) begin
        check($sformatf("rr%0d done_id", k), DoneId, k % 2);
        check($sformatf("rr%0d result", k), Result, (k % 2) ? 3'b111 : 3'b011);
        check($sformatf("rr%0d result_ovf", k), ResultOvf, 0);
        k++;
        if (k == 4) begin Req0 = 1'b0; Req1 = 1'b0; end
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    check("rr done_count", k, 4);
    @(negedge Clk);

    // reset during RUN aborts the job with no Done
    Req0 = 1'b1; Len0 = 4'd10;
    repeat (4) @(negedge Clk);
    check("abort in_run", CntEn, 1);
    Reset = 1'b1; Req0 = 1'b0;
    @(negedge Clk);
    check("abort busy", Busy, 0);
    check("abort grant", Grant, 0);
    check("abort cnt_reset", CntReset, 1);
    check("abort cnt_en", CntEn, 0);
    check("abort done", Done, 0);
    Reset = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge Clk);
      if (Done) nd++;
    end
    check("abort no_done", nd, 0);
    run_job(jobs[4], 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
